apb_cmd_master: RTL and testbench
=================================

# apb_cmd_master

Synthesizable APB initiator that turns single-beat command requests into APB transfers on the timer's register bus. It drives the same 8-bit address / 8-bit data APB slave port the timer exposes (TDR 0x00, TCR 0x01, TSR 0x02). It lets a hardware sequencer or interrupt handler program and poll the timer without the bench CPU model. One command is in flight at a time; a wait-state timeout protects against a hung slave.

## Interface
- `TIMEOUT`, default 16: maximum ACCESS cycles with `pready`=0 before the transfer is aborted. 0 disables the timeout.
- `pclk` input 1: single clock; all state changes on its rising edge.
- `preset` input 1: synchronous, active-high reset.
- `cmd_valid` input 1: command request.
- `cmd_ready` output 1: command accepted when `cmd_valid` and `cmd_ready` are both 1 at a rising edge.
- `cmd_write` input 1: 1 = write, 0 = read.
- `cmd_addr` input 8: register address.
- `cmd_wdata` input 8: write data; ignored for reads.
- `rsp_valid` output 1: one-cycle pulse, transfer finished.
- `rsp_rdata` output 8: read data. Valid with `rsp_valid`; 0 for writes and aborted transfers.
- `rsp_err` output 1: valid with `rsp_valid`. Set to `pslverr` OR timeout.
- `busy` output 1: high in SETUP or ACCESS.
- `psel`, `penable`, `pwrite` output 1 each: APB control.
- `paddr` output 8, `pwdata` output 8: APB address and write data.
- `prdata` input 8, `pready` input 1, `pslverr` input 1: APB slave response.

## Operation
- States:
  - IDLE: `psel`=0, `penable`=0.
  - SETUP: `psel`=1, `penable`=0.
  - ACCESS: `psel`=1, `penable`=1.
- `cmd_ready` = (state==IDLE) OR (state==ACCESS AND `pready`=1), so back-to-back commands are supported.
- IDLE → SETUP on accept. `paddr`, `pwrite` and `pwdata` are registered from the `cmd_*` inputs and stay stable until the next accept. For reads, `pwdata` is 0.
- SETUP → ACCESS unconditionally, after 1 cycle.
- ACCESS with `pready`=1 completes the transfer:
  - On completion, capture `prdata` (reads only) and `pslverr`.
  - Next state is SETUP if a new command is accepted in the same cycle, otherwise IDLE.
- ACCESS with `pready`=0 holds ACCESS and increments the 8-bit `wait_cnt`. `wait_cnt` clears on entry to SETUP.
- Timeout abort: in ACCESS with `pready`=0 and `wait_cnt`==`TIMEOUT`-1 (`TIMEOUT`≠0):
  - Go to IDLE; a command is not accepted in this cycle.
  - Response is `rsp_err`=1, `rsp_rdata`=0.
  - A late `pready` after the abort is ignored.
- `rsp_err` = `pslverr` sampled with `pready`, or timeout. `pslverr` is ignored while `pready`=0.
- Reset:
  - Any state returns to IDLE at the next edge; an in-flight transfer is dropped with no response.
  - All outputs reset to 0, except `cmd_ready`=1 in the cycle after reset deasserts.

## Timing
- Accept at edge N:
  - SETUP during cycle N..N+1.
  - ACCESS from edge N+1.
- Zero-wait slave: `pready`=1 sampled at edge N+2, `rsp_valid`=1 during cycle N+2..N+3. Accept-to-response latency is 3 edges.
- Each wait state adds one cycle.
- Back-to-back zero-wait commands give one transfer per 2 cycles, with `psel` held high continuously.
- `rsp_valid` is high for exactly one cycle per accepted command. It never overlaps a second response.
- Timeout with `TIMEOUT`=T: `rsp_valid`/`rsp_err` are asserted the cycle after the T-th ACCESS cycle with `pready`=0. `psel` is low in that same cycle.

## Test plan
- Write TDR: write 0x00 ← 0x64 to a zero-wait slave. Expect:
  - `psel` for 2 cycles, `penable` for 1 cycle, `pwdata`=0x64.
  - `rsp_valid` 3 edges after accept, `rsp_err`=0.
- Read TSR after underflow: read 0x02 with `prdata`=0x02 and 2 wait states. Expect `rsp_rdata`=0x02 5 edges after accept, `rsp_err`=0.
- Back-to-back writes: hold `cmd_valid` for TCR←0x80 then TCR←0x33. Expect:
  - The second SETUP immediately follows the first ACCESS.
  - Two `rsp_valid` pulses 2 cycles apart, `psel` never low between the transfers.
- Slave error: `pslverr`=1 with `pready` on a read. Expect `rsp_err`=1 and `rsp_rdata`=`prdata`.
- Timeout: `TIMEOUT`=4, `pready` held 0. Expect:
  - Abort after 4 ACCESS cycles, `rsp_err`=1, `rsp_rdata`=0, return to IDLE.
  - A later `pready` pulse produces no response.
- Reset mid-ACCESS: assert `preset` for 1 cycle. Expect:
  - All outputs 0 at the next edge, no `rsp_valid`.
  - A subsequent command completes normally.

Source files
------------

// File: rtl/apb_cmd_master.sv
// apb_cmd_master: single-outstanding command-to-APB initiator with a wait-state timeout
module apb_cmd_master #(
    parameter int TIMEOUT = 16
) (
    input  logic       pclk,
    input  logic       preset,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_write,
    input  logic [7:0] cmd_addr,
    input  logic [7:0] cmd_wdata,
    output logic       rsp_valid,
    output logic [7:0] rsp_rdata,
    output logic       rsp_err,
    output logic       busy,
    output logic       psel,
    output logic       penable,
    output logic       pwrite,
    output logic [7:0] paddr,
    output logic [7:0] pwdata,
    input  logic [7:0] prdata,
    input  logic       pready,
    input  logic       pslverr
);
    localparam logic [1:0] IDLE = 2'd0, SETUP = 2'd1, ACCESS = 2'd2;
    logic [1:0] r_state;
    logic [7:0] r_wait_cnt;
    logic       w_done, w_abort, w_accept;
    assign w_done    = (r_state == ACCESS) && pready;
    assign w_abort   = (TIMEOUT != 0) && (r_state == ACCESS) && !pready && (r_wait_cnt == 8'(TIMEOUT - 1));
    // held low during reset so the first accept can only happen after reset deasserts
    assign cmd_ready = !preset && ((r_state == IDLE) || w_done);
    assign w_accept  = cmd_valid && cmd_ready;
    assign psel      = r_state != IDLE;
    assign busy      = r_state != IDLE;
    assign penable   = r_state == ACCESS;
    always_ff @(posedge pclk) begin
        if (preset) begin
            r_state    <= IDLE;
            r_wait_cnt <= '0;
            pwrite     <= 1'b0;
            paddr      <= '0;
            pwdata     <= '0;
            rsp_valid  <= 1'b0;
            rsp_rdata  <= '0;
            rsp_err    <= 1'b0;
        end else begin
            r_state    <= w_accept ? SETUP : (r_state == SETUP) ? ACCESS : (w_done || w_abort) ? IDLE : r_state;
            r_wait_cnt <= w_accept ? 8'd0 : (r_state == ACCESS && !pready) ? r_wait_cnt + 8'd1 : r_wait_cnt;
            pwrite     <= w_accept ? cmd_write : pwrite;
            paddr      <= w_accept ? cmd_addr : paddr;
            pwdata     <= w_accept ? (cmd_write ? cmd_wdata : 8'd0) : pwdata;
            rsp_valid  <= w_done || w_abort;
            rsp_rdata  <= (w_done && !pwrite) ? prdata : 8'd0;
            rsp_err    <= w_done ? pslverr : w_abort;
        end
    end
endmodule

// File: tb/tb_apb_cmd_master.sv
// tb_apb_cmd_master: directed and randomized APB command checks against a transaction-level model
module tb_apb_cmd_master;
    localparam int T = 4;
    logic       pclk = 0, preset = 1, cmd_valid = 0, cmd_write = 0;
    logic [7:0] cmd_addr = 0, cmd_wdata = 0, prdata = 0;
    logic       pready = 0, pslverr = 0;
    logic       cmd_ready, rsp_valid, rsp_err, busy, psel, penable, pwrite;
    logic [7:0] rsp_rdata, paddr, pwdata;
    int         n_cmp = 0, n_fail = 0;
    int         sl_waits = 0, sl_cnt = 0;
    logic [7:0] sl_rdata = 0;
    logic       sl_err = 0, sl_force = 0;

    apb_cmd_master #(.TIMEOUT(T)) dut (
        .pclk(pclk), .preset(preset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy),
        .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
        .prdata(prdata), .pready(pready), .pslverr(pslverr)
    );

    always #5 pclk = ~pclk;

    // slave: answers after sl_waits wait states; junk on prdata/pslverr while not ready
    always @(negedge pclk) begin
        if (psel && penable) begin
            pready = (sl_cnt == sl_waits);
            sl_cnt = pready ? 0 : sl_cnt + 1;
        end else begin
            sl_cnt = 0;
            pready = sl_force;
        end
        prdata  = pready ? sl_rdata : 8'($urandom);
        pslverr = pready ? sl_err : 1'($urandom);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    task automatic xfer(input logic w, input logic [7:0] a, input logic [7:0] d, input int waits,
                        input logic [7:0] rd, input logic er);
        bit ok;
        int exp_lat, n, n_sel, n_en;
        bit got;
        ok = waits < T;
        exp_lat = ok ? 2 + waits : T + 1;
        n = 0; n_sel = 1; n_en = 0; got = 0;
        sl_waits = waits; sl_rdata = rd; sl_err = er;
        cmd_valid = 1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
        chk("ready_idle", cmd_ready, 1);
        tick();
        cmd_valid = 0; cmd_write = 1'($urandom); cmd_addr = 8'($urandom); cmd_wdata = 8'($urandom);
        chk("setup_ctrl", {psel, penable, busy}, 3'b101 | 3'b010 & 3'b000 | 3'b100);
        chk("setup_paddr", paddr, a);
        chk("setup_pwrite", pwrite, w);
        chk("setup_pwdata", pwdata, w ? d : 8'd0);
        while (!got && n < 40) begin
            tick();
            n++;
            n_sel += int'(psel);
            n_en += int'(penable);
            got = rsp_valid;
        end
        chk("rsp_seen", got, 1);
        chk("rsp_latency", n, exp_lat);
        chk("rsp_rdata", rsp_rdata, (ok && !w) ? rd : 8'd0);
        chk("rsp_err", rsp_err, ok ? er : 1'b1);
        chk("psel_cycles", n_sel, ok ? 2 + waits : T + 1);
        chk("penable_cycles", n_en, ok ? 1 + waits : T);
        chk("idle_at_rsp", {psel, busy}, 0);
        chk("paddr_hold", paddr, a);
        tick();
        chk("rsp_pulse", rsp_valid, 0);
    endtask

    initial begin
        bit e_sel[5] = '{1, 1, 1, 1, 0};
        bit e_en[5]  = '{0, 1, 0, 1, 0};
        bit e_rv[5]  = '{0, 0, 1, 0, 1};
        logic [7:0] e_wd[5] = '{8'h80, 8'h80, 8'h33, 8'h33, 8'h33};
        int wt;
        repeat (3) tick();
        chk("rst_ctrl", {psel, penable, pwrite, busy, rsp_valid, rsp_err, cmd_ready}, 0);
        chk("rst_bus", {paddr, pwdata, rsp_rdata}, 0);
        preset = 0;
        #1;
        chk("ready_after_rst", cmd_ready, 1);
        // write TDR, read TSR with 2 waits
        xfer(1, 8'h00, 8'h64, 0, 8'h00, 0);
        xfer(0, 8'h02, 8'h00, 2, 8'h02, 0);
        // back-to-back writes to TCR
        sl_waits = 0; sl_err = 0;
        cmd_valid = 1; cmd_write = 1; cmd_addr = 8'h01; cmd_wdata = 8'h80;
        tick();
        cmd_wdata = 8'h33;
        for (int i = 0; i < 5; i++) begin
            chk("b2b_psel", psel, e_sel[i]);
            chk("b2b_penable", penable, e_en[i]);
            chk("b2b_rsp", rsp_valid, e_rv[i]);
            chk("b2b_pwdata", pwdata, e_wd[i]);
            if (e_rv[i]) chk("b2b_err", rsp_err, 0);
            if (i == 2) cmd_valid = 0;
            if (i < 4) tick();
        end
        tick();
        chk("b2b_pulse", rsp_valid, 0);
        // slave errors on read and write
        xfer(0, 8'h01, 8'h00, 0, 8'hA5, 1);
        xfer(1, 8'h02, 8'h3C, 1, 8'hFF, 1);
        // wait-state boundary: T-1 waits completes, T waits times out
        xfer(0, 8'h00, 8'h00, T - 1, 8'h5E, 0);
        xfer(0, 8'h02, 8'h00, T, 8'h77, 0);
        xfer(1, 8'h01, 8'h11, 1000, 8'h77, 0);
        sl_force = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("late_pready_rsp", rsp_valid, 0);
            chk("late_pready_idle", psel, 0);
        end
        sl_force = 0;
        // reset in the middle of ACCESS
        sl_waits = 1000;
        cmd_valid = 1; cmd_write = 1; cmd_addr = 8'h01; cmd_wdata = 8'h5A;
        tick();
        cmd_valid = 0;
        tick();
        tick();
        chk("pre_rst_access", {psel, penable}, 2'b11);
        preset = 1;
        tick();
        chk("mid_rst_ctrl", {psel, penable, pwrite, busy, rsp_valid, rsp_err, cmd_ready}, 0);
        chk("mid_rst_bus", {paddr, pwdata, rsp_rdata}, 0);
        preset = 0;
        #1;
        chk("mid_rst_ready", cmd_ready, 1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("mid_rst_no_rsp", rsp_valid, 0);
        end
        xfer(0, 8'h02, 8'h00, 1, 8'hC3, 0);
        // randomized traffic
        for (int i = 0; i < 40; i++) begin
            wt = ($urandom_range(0, 7) == 0) ? T + int'($urandom_range(0, 3)) : int'($urandom_range(0, T - 1));
            xfer(1'($urandom), 8'($urandom_range(0, 2)), 8'($urandom), wt, 8'($urandom), 1'($urandom_range(0, 3) == 0));
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
